rib_xbar: RTL and testbench

Parametrised successor to the fixed 4-master/6-slave RIB interconnect: an N-master, M-slave shared bus with round-robin arbitration, top-address-bit slave decode, a registered read-data phase and decode-error reporting. It sits between the CPU data port (plus DMA or debug masters) and the memory/peripheral slaves (RAM, ROM, timer, UART, GPIO, SPI) in the SoC top. Non-granted requesters are stalled through `hold_flag_o`.

---
 rtl/rib_xbar.sv | 164 ++++++++++++++++
 tb/tb_rib_xbar.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_xbar.sv
// rtl/rib_xbar.sv - N-master/M-slave shared bus with round-robin arbitration and decode-error reporting
module rib_xbar #(
    parameter int NM = 4,
    parameter int NS = 6,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_re_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_data_i,
    input  logic [NM*3-1:0]  m_size_i,
    output logic [NM-1:0]    m_gnt_o,
    output logic [NM-1:0]    m_rvalid_o,
    output logic [DW-1:0]    m_data_o,
    output logic             hold_flag_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_data_o,
    output logic [2:0]       s_size_o,
    output logic [NS-1:0]    s_we_o,
    output logic [NS-1:0]    s_re_o,
    input  logic [NS*DW-1:0] s_data_i,
    output logic             err_o,
    output logic [AW-1:0]    err_addr_o
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [SB:0] NS_LIM = (SB+1)'(NS);
    localparam logic [0:0] ST_ADDR  = 1'b0;
    localparam logic [0:0] ST_RDATA = 1'b1;

    logic [0:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_gnt_q;
    logic [SB-1:0] r_idx_q;
    logic          r_rd_err;
    logic          r_err;
    logic [AW-1:0] r_err_addr;

    logic [NM-1:0] w_cand;
    logic [PW-1:0] w_win;
    int            w_best;
    int            w_dist;
    logic          w_grant;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [2:0]    w_size;
    logic          w_we;
    logic          w_re;
    logic [SB-1:0] w_idx;
    logic          w_dec_ok;

    assign w_cand = m_req_i & (m_we_i | m_re_i);

    // Winner is the candidate with the smallest cyclic distance from the pointer.
    always_comb begin
        w_best = NM;
        w_dist = 0;
        w_win  = '0;
        for (int k = 0; k < NM; k++) begin
            if (w_cand[k]) begin
                if (k >= int'(r_ptr)) w_dist = k - int'(r_ptr);
                else                  w_dist = k + NM - int'(r_ptr);
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_win  = PW'(k);
                end
            end
        end
    end

    assign w_grant = (r_state == ST_ADDR) && (w_best < NM);

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_size  = '0;
        w_we    = 1'b0;
        w_re    = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (w_grant && (w_win == PW'(k))) begin
                w_addr  = m_addr_i[k*AW +: AW];
                w_wdata = m_data_i[k*DW +: DW];
                w_size  = m_size_i[k*3 +: 3];
                w_we    = m_we_i[k];
                w_re    = m_re_i[k] & ~m_we_i[k];
            end
        end
    end

    assign w_idx    = w_addr[AW-1 -: SB];
    assign w_dec_ok = ({1'b0, w_idx} < NS_LIM);

    assign s_addr_o = w_addr;
    assign s_data_o = w_wdata;
    assign s_size_o = w_size;

    always_comb begin
        m_gnt_o = '0;
        for (int k = 0; k < NM; k++) begin
            m_gnt_o[k] = w_grant && (w_win == PW'(k));
        end
    end

    always_comb begin
        s_we_o = '0;
        s_re_o = '0;
        for (int s = 0; s < NS; s++) begin
            s_we_o[s] = w_we && w_dec_ok && (w_idx == SB'(s));
            s_re_o[s] = w_re && w_dec_ok && (w_idx == SB'(s));
        end
    end

    // An erroring read still completes its data phase, returning zero.
    always_comb begin
        m_rvalid_o = '0;
        m_data_o   = '0;
        for (int k = 0; k < NM; k++) begin
            m_rvalid_o[k] = (r_state == ST_RDATA) && (r_gnt_q == PW'(k));
        end
        for (int s = 0; s < NS; s++) begin
            if ((r_state == ST_RDATA) && !r_rd_err && (r_idx_q == SB'(s))) begin
                m_data_o = s_data_i[s*DW +: DW];
            end
        end
    end

    assign hold_flag_o = (r_state == ST_RDATA) || (|(w_cand & ~m_gnt_o));
    assign err_o       = r_err;
    assign err_addr_o  = r_err_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_ADDR;
            r_ptr      <= '0;
            r_gnt_q    <= '0;
            r_idx_q    <= '0;
            r_rd_err   <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= w_grant && !w_dec_ok;
            if (w_grant && !w_dec_ok) begin
                r_err_addr <= w_addr;
            end
            if (r_state == ST_RDATA) begin
                r_state <= ST_ADDR;
            end else if (w_grant) begin
                r_ptr <= (w_win == PW'(NM-1)) ? '0 : w_win + 1'b1;
                if (w_re) begin
                    r_state  <= ST_RDATA;
                    r_gnt_q  <= w_win;
                    r_idx_q  <= w_idx;
                    r_rd_err <= !w_dec_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_rib_xbar.sv
// tb/tb_rib_xbar.sv - self-checking bench for rib_xbar with directed scenarios and a randomized reference model
module tb_rib_xbar;

    localparam int NM = 4;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    m_req, m_we, m_re;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*3-1:0]  m_size;
    logic [NM-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata;
    logic             hold;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [2:0]       s_size;
    logic [NS-1:0]    s_we, s_re;
    logic [NS*DW-1:0] s_rdata;
    logic             err;
    logic [AW-1:0]    err_addr;

    int checks = 0;
    int errors = 0;

    rib_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SB(SB)) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_re_i(m_re),
        .m_addr_i(m_addr), .m_data_i(m_wdata), .m_size_i(m_size),
        .m_gnt_o(gnt), .m_rvalid_o(rvalid), .m_data_o(rdata), .hold_flag_o(hold),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_size_o(s_size),
        .s_we_o(s_we), .s_re_o(s_re), .s_data_i(s_rdata),
        .err_o(err), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req = '0; m_we = '0; m_re = '0;
        m_addr = '0; m_wdata = '0; m_size = '0;
        s_rdata = '0;
    endtask

    task automatic set_m(input int k, input logic req, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        m_req[k] = req; m_we[k] = we; m_re[k] = re;
        m_addr[k*AW +: AW] = a;
        m_wdata[k*DW +: DW] = d;
        m_size[k*3 +: 3] = sz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1 rst = 1'b0;
        step();
        #1;
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", hold); end
        checks++; if (err !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_err: got %b/%h expected 0/0", err, err_addr); end
        checks++; if (s_we !== 6'b0 || s_re !== 6'b0 || s_addr !== 32'h0) begin errors++; $display("FAIL reset_slave: got we=%b re=%b addr=%h expected zeros", s_we, s_re, s_addr); end
        rst = 1'b1;
        step();
        set_m(2, 1'b1, 1'b0, 1'b1, 32'h3000_0000, 32'h0, 3'd2);
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL reset_pre_gnt: got %b expected 0100", gnt); end
        step();
        clear_inputs();
        #1;
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL reset_pre_rvalid: got %b expected 0100", rvalid); end
        rst = 1'b0;
        #1;
        checks++; if (rvalid !== 4'b0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_abort: got rvalid=%b data=%h expected 0/0", rvalid, rdata); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_abort_hold: got %b expected 0", hold); end
        step();
        rst = 1'b1;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h11, 3'd2);
        set_m(3, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h33, 3'd2);
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0010", gnt); end
        step();
        clear_inputs();
    endtask

    task automatic test_write();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2);
        #1;
        checks++; if (s_we !== 6'b000001) begin errors++; $display("FAIL write_we: got %b expected 000001", s_we); end
        checks++; if (s_re !== 6'b0) begin errors++; $display("FAIL write_re: got %b expected 000000", s_re); end
        checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL write_addr: got %h expected 00000010", s_addr); end
        checks++; if (s_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_data: got %h expected deadbeef", s_wdata); end
        checks++; if (s_size !== 3'd2) begin errors++; $display("FAIL write_size: got %0d expected 2", s_size); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL write_hold: got %b expected 0", hold); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL write_gnt: got %b expected 0001", gnt); end
        step();
        clear_inputs();
    endtask

    task automatic test_read();
        set_m(2, 1'b1, 1'b0, 1'b1, 32'h3000_0004, 32'h0, 3'd2);
        #1;
        checks++; if (s_re !== 6'b001000) begin errors++; $display("FAIL read_re: got %b expected 001000", s_re); end
        checks++; if (s_we !== 6'b0) begin errors++; $display("FAIL read_we: got %b expected 000000", s_we); end
        checks++; if (s_addr !== 32'h3000_0004) begin errors++; $display("FAIL read_addr: got %h expected 30000004", s_addr); end
        step();
        clear_inputs();
        for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom;
        s_rdata[3*DW +: DW] = 32'h1234_5678;
        #1;
        checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL read_rvalid: got %b expected 0100", rvalid); end
        checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", rdata); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL read_hold: got %b expected 1", hold); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL read_rdata_gnt: got %b expected 0000", gnt); end
        step();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int order[3] = '{0, 1, 3};
        logic [3:0] exp_g;
        rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hA0, 3'd2);
            set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0100, 32'hA1, 3'd2);
            set_m(3, 1'b1, 1'b1, 1'b0, 32'h2000_0100, 32'hA3, 3'd2);
            #1;
            exp_g = 4'(1 << order[i % 3]);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g); end
            checks++; if (hold !== 1'b1) begin errors++; $display("FAIL rr_hold[%0d]: got %b expected 1", i, hold); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_decode_error();
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h7000_0000, 32'h0, 3'd2);
        #1;
        checks++; if (s_re !== 6'b0 || s_we !== 6'b0) begin errors++; $display("FAIL derr_rd_strobe: got we=%b re=%b expected 0/0", s_we, s_re); end
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL derr_rd_gnt: got %b expected 0010", gnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL derr_rd_early: got %b expected 0", err); end
        step();
        clear_inputs();
        for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom | 32'h1;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL derr_rd_err: got %b expected 1", err); end
        checks++; if (err_addr !== 32'h7000_0000) begin errors++; $display("FAIL derr_rd_addr: got %h expected 70000000", err_addr); end
        checks++; if (rvalid !== 4'b0010 || rdata !== 32'h0) begin errors++; $display("FAIL derr_rd_rvalid: got %b/%h expected 0010/0", rvalid, rdata); end
        step();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 32'h55, 3'd2);
        #1;
        checks++; if (s_we !== 6'b0 || gnt !== 4'b0001) begin errors++; $display("FAIL derr_wr_strobe: got we=%b gnt=%b expected 000000/0001", s_we, gnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL derr_wr_early: got %b expected 0", err); end
        step();
        clear_inputs();
        #1;
        checks++; if (err !== 1'b1 || err_addr !== 32'hF000_0000) begin errors++; $display("FAIL derr_wr_err: got %b/%h expected 1/f0000000", err, err_addr); end
        checks++; if (rvalid !== 4'b0) begin errors++; $display("FAIL derr_wr_rvalid: got %b expected 0000", rvalid); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL derr_pulse: got %b expected 0", err); end
    endtask

    task automatic test_we_re();
        set_m(3, 1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'hCAFE, 3'd1);
        #1;
        checks++; if (s_we !== 6'b000100 || s_re !== 6'b0) begin errors++; $display("FAIL wr_both_strobe: got we=%b re=%b expected 000100/000000", s_we, s_re); end
        step();
        clear_inputs();
        #1;
        checks++; if (rvalid !== 4'b0 || hold !== 1'b0) begin errors++; $display("FAIL wr_both_state: got rvalid=%b hold=%b expected 0000/0", rvalid, hold); end
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 3'd2);
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_both_next_gnt: got %b expected 0001", gnt); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        bit pend[NM];
        logic [31:0] pa[NM], pd[NM];
        bit pwe[NM], pre[NM];
        logic [2:0] psz[NM];
        int mptr, mgm, mgs, win, bestd, ncand, sl, kind;
        bit mrd, mrerr, merr;
        logic [31:0] merr_addr;
        logic [3:0] eg, erv;
        logic [5:0] ewe, ere;
        logic [31:0] eaddr, ewd, edata;
        logic [2:0] esz;
        logic ehold;
        rst = 1'b0;
        #1 rst = 1'b1;
        mptr = 0; mrd = 0; mgm = 0; mgs = 0; mrerr = 0; merr = 0; merr_addr = '0;
        for (int k = 0; k < NM; k++) pend[k] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NM; k++) begin
                if (!pend[k] && $urandom_range(0, 2) != 0) begin
                    pend[k] = 1;
                    kind = $urandom_range(0, 3);
                    pwe[k] = (kind == 0) || (kind == 2);
                    pre[k] = (kind != 0);
                    pa[k] = $urandom;
                    pa[k][31:28] = 4'($urandom_range(0, 7));
                    if ($urandom_range(0, 9) == 0) pa[k][31:28] = 4'hF;
                    pd[k] = $urandom;
                    psz[k] = 3'($urandom_range(0, 7));
                end
                if (pend[k]) set_m(k, 1'b1, pwe[k], pre[k], pa[k], pd[k], psz[k]);
                else set_m(k, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom, 3'd0);
            end
            for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom;
            #1;
            win = -1; sl = 0;
            eg = '0; ewe = '0; ere = '0; eaddr = '0; ewd = '0; esz = '0; erv = '0; edata = '0;
            if (mrd) begin
                erv = 4'(1 << mgm);
                edata = mrerr ? 32'h0 : s_rdata[mgs*DW +: DW];
                ehold = 1'b1;
            end else begin
                bestd = NM; ncand = 0;
                for (int k = 0; k < NM; k++) begin
                    if (pend[k]) begin
                        ncand++;
                        if ((k - mptr + NM) % NM < bestd) begin
                            bestd = (k - mptr + NM) % NM;
                            win = k;
                        end
                    end
                end
                ehold = (ncand > 1);
                if (win >= 0) begin
                    eg = 4'(1 << win);
                    eaddr = pa[win]; ewd = pd[win]; esz = psz[win];
                    sl = int'(pa[win][31:28]);
                    if (sl < NS && pwe[win]) ewe = 6'(1 << sl);
                    if (sl < NS && !pwe[win] && pre[win]) ere = 6'(1 << sl);
                end
            end
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, eg); end
            checks++; if (s_we !== ewe) begin errors++; $display("FAIL rnd_we[%0d]: got %b expected %b", c, s_we, ewe); end
            checks++; if (s_re !== ere) begin errors++; $display("FAIL rnd_re[%0d]: got %b expected %b", c, s_re, ere); end
            checks++; if (s_addr !== eaddr || s_wdata !== ewd || s_size !== esz) begin errors++; $display("FAIL rnd_fwd[%0d]: got %h/%h/%0d expected %h/%h/%0d", c, s_addr, s_wdata, s_size, eaddr, ewd, esz); end
            checks++; if (rvalid !== erv || rdata !== edata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %b/%h expected %b/%h", c, rvalid, rdata, erv, edata); end
            checks++; if (hold !== ehold) begin errors++; $display("FAIL rnd_hold[%0d]: got %b expected %b", c, hold, ehold); end
            checks++; if (err !== merr || err_addr !== merr_addr) begin errors++; $display("FAIL rnd_err[%0d]: got %b/%h expected %b/%h", c, err, err_addr, merr, merr_addr); end
            merr = (win >= 0) && (sl >= NS);
            if (merr) merr_addr = pa[win];
            if (mrd) mrd = 0;
            else if (win >= 0) begin
                pend[win] = 0;
                mptr = (win + 1) % NM;
                if (!pwe[win]) begin
                    mrd = 1; mgm = win; mgs = sl; mrerr = (sl >= NS);
                end
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_decode_error();
        test_we_re();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
